// File: rtl/axi_wresp_ch.sv
// AXI write-response channel: in-order ID/fault FIFO, completed-burst counter and B-response FSM.
// Optional downstream BID check is enabled by defining WRESP_ID_CHECK_EN.
module axi_wresp_ch #(
    parameter int ID_WIDTH       = 4,
    parameter int OUTSTANDING    = 8,
    parameter int LAST_CNT_WIDTH = 4
) (
    input  logic                           clk,
    input  logic                           reset_,
    input  logic [ID_WIDTH-1:0]            in_awid,
    input  logic                           in_awfault,
    input  logic                           in_awpush,
    output logic                           out_awfull,
    input  logic                           in_wlast_done,
    input  logic [ID_WIDTH-1:0]            in_mbid,
    input  logic [1:0]                     in_mbresp,
    input  logic                           in_mbvalid,
    output logic                           out_mbready,
    output logic [ID_WIDTH-1:0]            out_sbid,
    output logic [1:0]                     out_sbresp,
    output logic                           out_sbvalid,
    input  logic                           in_sbready,
    output logic [$clog2(OUTSTANDING):0]   out_pending,
    output logic                           out_id_err
);
    localparam int PTR_W = $clog2(OUTSTANDING);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [LAST_CNT_WIDTH-1:0] WCNT_MAX = {LAST_CNT_WIDTH{1'b1}};

    typedef enum logic [1:0] {IDLE, WAIT_LAST, WAIT_B, SEND} state_t;

    state_t                    state;
    logic [ID_WIDTH-1:0]       id_mem [OUTSTANDING];
    logic                      fault_mem [OUTSTANDING];
    logic [PTR_W-1:0]          wr_ptr;
    logic [PTR_W-1:0]          rd_ptr;
    logic [CNT_W-1:0]          pend_nxt;
    logic [LAST_CNT_WIDTH-1:0] wcnt;
    logic                      push;
    logic                      pop;
    logic                      consume;
    logic [ID_WIDTH-1:0]       head_id;
    logic                      head_fault;

    assign push       = in_awpush & ~out_awfull;
    assign pop        = (state == SEND) & in_sbready;
    assign consume    = (state == WAIT_LAST) & (wcnt != '0);
    assign head_id    = id_mem[rd_ptr];
    assign head_fault = fault_mem[rd_ptr];
    assign pend_nxt   = out_pending + CNT_W'(push) - CNT_W'(pop);

    // Storage needs no reset: entries are only read once counted in out_pending.
    always_ff @(posedge clk) begin
        if (push) begin
            id_mem[wr_ptr]    <= in_awid;
            fault_mem[wr_ptr] <= in_awfault;
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            out_pending <= '0;
            out_awfull  <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            out_pending <= pend_nxt;
            out_awfull  <= (pend_nxt == CNT_W'(OUTSTANDING));
        end
    end

    // Increment saturates at the maximum; a simultaneous increment and consume cancel.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            wcnt <= '0;
        end else if (in_wlast_done && !consume && wcnt != WCNT_MAX) begin
            wcnt <= wcnt + LAST_CNT_WIDTH'(1);
        end else if (consume && !in_wlast_done) begin
            wcnt <= wcnt - LAST_CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state       <= IDLE;
            out_sbid    <= '0;
            out_sbresp  <= 2'b00;
            out_sbvalid <= 1'b0;
            out_mbready <= 1'b0;
`ifdef WRESP_ID_CHECK_EN
            out_id_err  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (out_pending != '0) state <= WAIT_LAST;
                end
                WAIT_LAST: begin
                    if (consume) begin
                        if (head_fault) begin
                            out_sbid    <= head_id;
                            out_sbresp  <= 2'b10;
                            out_sbvalid <= 1'b1;
                            state       <= SEND;
                        end else begin
                            out_mbready <= 1'b1;
                            state       <= WAIT_B;
                        end
                    end
                end
                WAIT_B: begin
                    if (in_mbvalid) begin
                        out_sbid    <= head_id;
                        out_sbresp  <= in_mbresp;
`ifdef WRESP_ID_CHECK_EN
                        if (in_mbid != head_id) begin
                            out_sbresp <= 2'b10;
                            out_id_err <= 1'b1;
                        end
`endif
                        out_mbready <= 1'b0;
                        out_sbvalid <= 1'b1;
                        state       <= SEND;
                    end
                end
                SEND: begin
                    if (in_sbready) begin
                        out_sbvalid <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifndef WRESP_ID_CHECK_EN
    logic unused_mbid;
    assign unused_mbid = ^in_mbid;
    assign out_id_err  = 1'b0;
`endif

endmodule

// File: tb/tb_axi_wresp_ch.sv
// Directed bench for axi_wresp_ch: table of single-write transactions plus hand sequences
// for fault latency, ordering under backpressure, FIFO full and asynchronous reset.
module tb_axi_wresp_ch;
    localparam int IDW = 4;
`ifdef WRESP_ID_CHECK_EN
    localparam bit IDC = 1'b1;
`else
    localparam bit IDC = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           reset_ = 1'b0;
    logic [IDW-1:0] in_awid = '0;
    logic           in_awfault = 1'b0;
    logic           in_awpush = 1'b0;
    logic           out_awfull;
    logic           in_wlast_done = 1'b0;
    logic [IDW-1:0] in_mbid = '0;
    logic [1:0]     in_mbresp = 2'b00;
    logic           in_mbvalid = 1'b0;
    logic           out_mbready;
    logic [IDW-1:0] out_sbid;
    logic [1:0]     out_sbresp;
    logic           out_sbvalid;
    logic           in_sbready = 1'b0;
    logic [3:0]     out_pending;
    logic           out_id_err;

    int n_checks = 0;
    int n_fail   = 0;
    logic [IDW-1:0] exp_q[$];

    axi_wresp_ch dut (
        .clk(clk), .reset_(reset_),
        .in_awid(in_awid), .in_awfault(in_awfault), .in_awpush(in_awpush), .out_awfull(out_awfull),
        .in_wlast_done(in_wlast_done),
        .in_mbid(in_mbid), .in_mbresp(in_mbresp), .in_mbvalid(in_mbvalid), .out_mbready(out_mbready),
        .out_sbid(out_sbid), .out_sbresp(out_sbresp), .out_sbvalid(out_sbvalid), .in_sbready(in_sbready),
        .out_pending(out_pending), .out_id_err(out_id_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [IDW-1:0] id;
        logic           fault;
        logic [IDW-1:0] mbid;
        logic [1:0]     mbresp;
        logic [1:0]     exp_resp;
        logic           exp_err;
    } vec_t;
    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [IDW-1:0] id, input logic fault);
        in_awid    = id;
        in_awfault = fault;
        in_awpush  = 1'b1;
        tick();
        in_awpush  = 1'b0;
    endtask

    task automatic pulse_wlast();
        in_wlast_done = 1'b1;
        tick();
        in_wlast_done = 1'b0;
    endtask

    task automatic wait_mbready(input string name);
        int n = 0;
        while (!out_mbready && n < 20) begin
            tick();
            n++;
        end
        if (!out_mbready) check({name, "_mbready_timeout"}, 32'd0, 32'd1);
    endtask

    // Single write, end to end; leaves the DUT idle and empty.
    task automatic run_txn(input vec_t v, input int idx);
        string nm = $sformatf("vec%0d", idx);
        int n = 0;
        logic saw_mbready = 1'b0;
        push(v.id, v.fault);
        check({nm, "_pending1"}, 32'(out_pending), 32'd1);
        pulse_wlast();
        if (v.fault) begin
            while (!out_sbvalid && n < 20) begin
                saw_mbready |= out_mbready;
                tick();
                n++;
            end
            check({nm, "_mbready_stays0"}, 32'(saw_mbready | out_mbready), 32'd0);
        end else begin
            wait_mbready(nm);
            in_mbvalid = 1'b1;
            in_mbid    = v.mbid;
            in_mbresp  = v.mbresp;
            tick();
            in_mbvalid = 1'b0;
        end
        check({nm, "_sbvalid"}, 32'(out_sbvalid), 32'd1);
        check({nm, "_sbid"}, 32'(out_sbid), 32'(v.id));
        check({nm, "_sbresp"}, 32'(out_sbresp), 32'(v.exp_resp));
        check({nm, "_id_err"}, 32'(out_id_err), 32'(v.exp_err));
        in_sbready = 1'b1;
        tick();
        in_sbready = 1'b0;
        check({nm, "_sbvalid_drop"}, 32'(out_sbvalid), 32'd0);
        check({nm, "_pending0"}, 32'(out_pending), 32'd0);
    endtask

    initial begin
        vecs[0] = '{id: 4'h3, fault: 1'b0, mbid: 4'h3, mbresp: 2'b00, exp_resp: 2'b00, exp_err: 1'b0};
        vecs[1] = '{id: 4'h5, fault: 1'b1, mbid: 4'h0, mbresp: 2'b00, exp_resp: 2'b10, exp_err: 1'b0};
        vecs[2] = '{id: 4'h9, fault: 1'b0, mbid: 4'h9, mbresp: 2'b11, exp_resp: 2'b11, exp_err: 1'b0};
        vecs[3] = '{id: 4'hF, fault: 1'b0, mbid: 4'hF, mbresp: 2'b01, exp_resp: 2'b01, exp_err: 1'b0};
        vecs[4] = '{id: 4'h2, fault: 1'b0, mbid: 4'h7, mbresp: 2'b00,
                    exp_resp: (IDC ? 2'b10 : 2'b00), exp_err: IDC};
        vecs[5] = '{id: 4'h0, fault: 1'b1, mbid: 4'h0, mbresp: 2'b00, exp_resp: 2'b10, exp_err: IDC};
        vecs[6] = '{id: 4'h6, fault: 1'b0, mbid: 4'h6, mbresp: 2'b10, exp_resp: 2'b10, exp_err: IDC};

        // Reset values
        #12;
        check("rst_sbvalid", 32'(out_sbvalid), 32'd0);
        check("rst_sbid", 32'(out_sbid), 32'd0);
        check("rst_sbresp", 32'(out_sbresp), 32'd0);
        check("rst_mbready", 32'(out_mbready), 32'd0);
        check("rst_awfull", 32'(out_awfull), 32'd0);
        check("rst_pending", 32'(out_pending), 32'd0);
        check("rst_id_err", 32'(out_id_err), 32'd0);
        @(negedge clk);
        reset_ = 1'b1;
        tick();

        for (int i = 0; i < 7; i++) run_txn(vecs[i], i);
        tick();

        // Fault-path latency with a burst already counted
        pulse_wlast();
        push(4'h5, 1'b1);
        check("flt_N_pending", 32'(out_pending), 32'd1);
        check("flt_N_sbvalid", 32'(out_sbvalid), 32'd0);
        tick();
        check("flt_N1_sbvalid", 32'(out_sbvalid), 32'd0);
        tick();
        check("flt_N2_sbvalid", 32'(out_sbvalid), 32'd1);
        check("flt_N2_sbid", 32'(out_sbid), 32'd5);
        check("flt_N2_sbresp", 32'(out_sbresp), 32'd2);
        check("flt_mbready", 32'(out_mbready), 32'd0);
        in_sbready = 1'b1;
        tick();
        in_sbready = 1'b0;
        check("flt_pending0", 32'(out_pending), 32'd0);
        tick();

        // Ordering with a 10-cycle upstream stall on every response
        for (int k = 1; k <= 3; k++) begin
            exp_q.push_back(IDW'(k));
            push(IDW'(k), 1'b0);
        end
        check("ord_pending3", 32'(out_pending), 32'd3);
        in_wlast_done = 1'b1;
        tick(); tick(); tick();
        in_wlast_done = 1'b0;
        for (int k = 0; k < 3; k++) begin
            logic [IDW-1:0] e;
            e = exp_q.pop_front();
            wait_mbready("ord");
            in_mbvalid = 1'b1;
            in_mbid    = e;
            in_mbresp  = 2'(k);
            tick();
            in_mbvalid = 1'b0;
            for (int c = 0; c < 10; c++) begin
                check($sformatf("ord%0d_valid_c%0d", k, c), 32'(out_sbvalid), 32'd1);
                check($sformatf("ord%0d_id_c%0d", k, c), 32'(out_sbid), 32'(e));
                check($sformatf("ord%0d_resp_c%0d", k, c), 32'(out_sbresp), 32'(k));
                tick();
            end
            in_sbready = 1'b1;
            tick();
            in_sbready = 1'b0;
            check($sformatf("ord%0d_pending", k), 32'(out_pending), 32'(2 - k));
        end
        tick();

        // FIFO full: 9 pushes, no drain
        for (int k = 0; k < 9; k++) begin
            push(IDW'(k), 1'b0);
            if (k == 6) check("full_after7", 32'(out_awfull), 32'd0);
            if (k == 7) begin
                check("full_after8", 32'(out_awfull), 32'd1);
                check("full_pending8", 32'(out_pending), 32'd8);
            end
        end
        check("full_after9_pending", 32'(out_pending), 32'd8);
        check("full_after9_awfull", 32'(out_awfull), 32'd1);

        // Asynchronous reset mid-operation, with counted bursts outstanding
        pulse_wlast();
        wait_mbready("rst_mid");
        @(negedge clk);
        #2;
        reset_ = 1'b0;
        #1;
        check("arst_pending", 32'(out_pending), 32'd0);
        check("arst_awfull", 32'(out_awfull), 32'd0);
        check("arst_mbready", 32'(out_mbready), 32'd0);
        check("arst_sbvalid", 32'(out_sbvalid), 32'd0);
        @(negedge clk);
        reset_ = 1'b1;
        tick();
        // Burst count was cleared: a faulted write must wait for a fresh wlast
        push(4'hA, 1'b1);
        for (int c = 0; c < 5; c++) begin
            check($sformatf("arst_nosb_c%0d", c), 32'(out_sbvalid), 32'd0);
            tick();
        end
        pulse_wlast();
        tick();
        check("arst_new_sbvalid", 32'(out_sbvalid), 32'd1);
        check("arst_new_sbid", 32'(out_sbid), 32'hA);
        in_sbready = 1'b1;
        tick();
        in_sbready = 1'b0;
        check("arst_new_pending0", 32'(out_pending), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/axi_wresp_ch.md
# axi_wresp_ch

Write-response channel transmitter for the AXI MMU write path. Records each write address accepted upstream in order, counts completed write-data bursts, and returns one B response per write to the upstream master. A write flagged as a translation fault gets a local SLVERR and is never sent downstream. All other writes forward the downstream B response, using the recorded ID.

## Interface
Parameters:
- ID_WIDTH, 4, AXI ID width.
- OUTSTANDING, 8, depth of the ID FIFO, power of 2.
- LAST_CNT_WIDTH, 4, width of the completed-burst counter.

Ports:
- clk  in  1  Single clock.
- reset_  in  1  Asynchronous, active-low reset.
- in_awid  in  ID_WIDTH  ID of the accepted write address.
- in_awfault  in  1  The write address failed translation.
- in_awpush  in  1  One write address accepted this cycle.
- out_awfull  out  1  ID FIFO full. Upstream must not push.
- in_wlast_done  in  1  One-cycle pulse when a wlast beat completes (forwarded or discarded).
- in_mbid  in  ID_WIDTH  Downstream BID.
- in_mbresp  in  2  Downstream BRESP.
- in_mbvalid  in  1  Downstream BVALID.
- out_mbready  out  1  Downstream BREADY.
- out_sbid  out  ID_WIDTH  Upstream BID.
- out_sbresp  out  2  Upstream BRESP.
- out_sbvalid  out  1  Upstream BVALID.
- in_sbready  in  1  Upstream BREADY.
- out_pending  out  $clog2(OUTSTANDING)+1  Number of occupied FIFO entries.
- out_id_err  out  1  Sticky flag: downstream ID mismatch.

## Operation
- ID FIFO, entries {id, fault}:
  - Push on in_awpush & ~out_awfull. A push while full is dropped with no state change.
  - Pop on the SEND handshake.
  - Push and pop in the same cycle are both legal; out_pending is unchanged.
- Burst counter wcnt:
  - +1 on in_wlast_done; -1 when the FSM consumes a burst.
  - Both in the same cycle: unchanged.
  - At the maximum value an increment is dropped (saturates).
- FSM states and transitions:
  - IDLE: go to WAIT_LAST if the FIFO is non-empty.
  - WAIT_LAST: when wcnt>0, consume one burst. If the head entry has fault=1, load out_sbid=head id and out_sbresp=2'b10, then go to SEND. Otherwise go to WAIT_B.
  - WAIT_B: out_mbready=1 only in this state. On in_mbvalid, load out_sbid=head id and out_sbresp=in_mbresp, then go to SEND.
  - SEND: out_sbvalid=1. On in_sbready, pop the FIFO and go to IDLE.
- Responses leave strictly in address order.
- Faulted writes never reach downstream, so no downstream B is ever expected for them.

## Timing
- Reset values:
  - All outputs 0: out_sbvalid, out_sbid, out_sbresp, out_mbready, out_awfull, out_pending, out_id_err.
  - FIFO empty, wcnt=0, FSM in IDLE.
- Reset asserted mid-operation: state clears immediately (asynchronous). Pending responses are discarded and no B is issued for them.
- out_sbid and out_sbresp are registered and held stable while out_sbvalid & ~in_sbready.
- out_mbready is registered from the state.
- Fault-path latency, with wcnt>0: push at edge N, then IDLE→WAIT_LAST at N+1 and WAIT_LAST→SEND at N+2. out_sbvalid is high after edge N+2.
- Forward-path latency: out_sbvalid is high one edge after the in_mbvalid & out_mbready handshake.
- Throughput: one extra cycle (SEND→IDLE) between consecutive responses, which gives at most one response per 3 cycles.
- out_awfull and out_pending are registered. They update on the edge after a push or pop.

## Configuration
- WRESP_ID_CHECK_EN defined:
  - In WAIT_B, compare in_mbid to the head id.
  - On mismatch, load out_sbresp=2'b10 (out_sbid stays the head id) and set out_id_err. out_id_err stays set until reset.
- WRESP_ID_CHECK_EN undefined:
  - in_mbid is ignored and in_mbresp passes through unchanged.
  - out_id_err is tied to 0.

## Test plan
- Reset check: assert reset_=0 mid-burst, then release → all outputs 0, out_pending=0, no out_sbvalid until a new push.
- Forward path: push id=3, fault=0; pulse in_wlast_done; drive in_mbvalid with in_mbresp=2'b00 → out_sbvalid with out_sbid=3, out_sbresp=2'b00. out_pending goes 1→0 after in_sbready.
- Fault path: push id=5, fault=1; pulse in_wlast_done → out_sbresp=2'b10, out_sbid=5, out_sbvalid high after edge N+2. out_mbready stays 0 throughout.
- Ordering and backpressure: push ids 1, 2, 3 back-to-back; hold in_sbready=0 for 10 cycles → outputs stable during the stall, and responses return in order 1, 2, 3.
- Full condition (OUTSTANDING=8): push 9 times with no drain → out_awfull=1 after the 8th push, the 9th push is dropped, out_pending=8.
- ID check: head id=2, in_mbid=7 → with WRESP_ID_CHECK_EN, out_sbresp=2'b10, out_sbid=2, out_id_err=1 (sticky). Without the macro, out_sbresp equals in_mbresp.
